// File: rtl/game_sequencer.sv
// game_sequencer: colour-memory game that grows a random sequence each round,
// replays it on the display, then checks the player's entries against it.
module game_sequencer #(
  parameter int unsigned COLOR_W       = 2,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned TIMEOUT_TICKS = 8,
  localparam int unsigned LEN_W        = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [COLOR_W-1:0] rand_i,
  input  logic [COLOR_W-1:0] in_i,
  input  logic               in_valid_i,
  input  logic               timer_pulse_i,
  output logic               timer_go_o,
  output logic [COLOR_W-1:0] out_o,
  output logic               out_ena_o,
  output logic               busy_o,
  output logic               win_o,
  output logic               lose_o,
  output logic               hs_o,
  output logic [LEN_W-1:0]   score_o,
  output logic [LEN_W-1:0]   high_score_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW,
    S_GAP,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_e;

  state_e             state_q;
  logic [COLOR_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   idx_q;
  logic [TW-1:0]      tmo_q;
  logic [LEN_W-1:0]   score_q;
  logic [LEN_W-1:0]   high_q;
  logic [COLOR_W-1:0] out_q;
  logic               ena_q;
  logic               go_q;
  logic               win_q;
  logic               lose_q;
  logic               hs_q;

  logic [LEN_W-1:0]   idx_inc;
  logic [TW-1:0]      tmo_inc;
  logic               last_w;
  logic               full_w;
  logic               best_w;
  logic [COLOR_W-1:0] cur_c;
  logic [COLOR_W-1:0] nxt_c;
  logic [COLOR_W-1:0] head_c;

  assign idx_inc = idx_q + 1'b1;
  assign tmo_inc = tmo_q + 1'b1;
  assign last_w  = (idx_inc == cnt_q);
  assign full_w  = (cnt_q == LEN_W'(DEPTH));
  assign best_w  = (score_q > high_q);
  assign cur_c   = mem_q[idx_q[AW-1:0]];
  assign nxt_c   = mem_q[idx_inc[AW-1:0]];
  assign head_c  = mem_q[AW'(0)];

  // Sequence storage carries no reset; only the first cnt entries are ever read.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ADD && !full_w) begin
      mem_q[cnt_q[AW-1:0]] <= rand_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      score_q <= '0;
      high_q  <= '0;
      out_q   <= '1;
      ena_q   <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      go_q <= 1'b0;
      hs_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q   <= '0;
            score_q <= '0;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (full_w) begin
            win_q   <= 1'b1;
            state_q <= S_WIN;
            if (best_w) begin
              high_q <= score_q;
              hs_q   <= 1'b1;
            end
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            idx_q   <= '0;
            go_q    <= 1'b1;
            out_q   <= (cnt_q == '0) ? rand_i : head_c;
            ena_q   <= 1'b1;
            state_q <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (timer_pulse_i) begin
            ena_q   <= 1'b0;
            go_q    <= 1'b1;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (timer_pulse_i) begin
            go_q <= 1'b1;
            if (last_w) begin
              idx_q   <= '0;
              tmo_q   <= '0;
              state_q <= S_INPUT;
            end else begin
              idx_q   <= idx_inc;
              out_q   <= nxt_c;
              ena_q   <= 1'b1;
              state_q <= S_SHOW;
            end
          end
        end
        S_INPUT: begin
          if (in_valid_i) begin
            if (in_i == cur_c) begin
              tmo_q <= '0;
              go_q  <= 1'b1;
              if (last_w) begin
                score_q <= score_q + 1'b1;
                state_q <= S_ADD;
              end else begin
                idx_q <= idx_inc;
              end
            end else begin
              lose_q  <= 1'b1;
              state_q <= S_LOSE;
              if (best_w) begin
                high_q <= score_q;
                hs_q   <= 1'b1;
              end
            end
          end else if (timer_pulse_i) begin
            if (tmo_inc == TW'(TIMEOUT_TICKS)) begin
              lose_q  <= 1'b1;
              state_q <= S_LOSE;
              if (best_w) begin
                high_q <= score_q;
                hs_q   <= 1'b1;
              end
            end else begin
              tmo_q <= tmo_inc;
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (start_i) begin
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            score_q <= '0;
            cnt_q   <= '0;
            state_q <= S_ADD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign timer_go_o   = go_q;
  assign out_o        = out_q;
  assign out_ena_o    = ena_q;
  assign busy_o       = state_q inside {S_ADD, S_SHOW, S_GAP, S_INPUT};
  assign win_o        = win_q;
  assign lose_o       = lose_q;
  assign hs_o         = hs_q;
  assign score_o      = score_q;
  assign high_score_o = high_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed vectors, hand-written corner sequences and
// randomized play checked against a queue-based model of the game rules.
module tb_game_sequencer;

  localparam int CW = 2;
  localparam int DP = 4;
  localparam int TO = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] rnd;
  logic [CW-1:0] inp;
  logic          vld;
  logic          tp;
  logic          tgo;
  logic [CW-1:0] out;
  logic          ena;
  logic          busy;
  logic          win;
  logic          lose;
  logic          hs;
  logic [LW-1:0] score;
  logic [LW-1:0] high;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .COLOR_W(CW),
    .DEPTH(DP),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .rand_i(rnd),
    .in_i(inp),
    .in_valid_i(vld),
    .timer_pulse_i(tp),
    .timer_go_o(tgo),
    .out_o(out),
    .out_ena_o(ena),
    .busy_o(busy),
    .win_o(win),
    .lose_o(lose),
    .hs_o(hs),
    .score_o(score),
    .high_score_o(high)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [1:0]  r;
    logic [1:0]  i;
    logic        v;
    logic        t;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [13:0] pk(
    input logic en, input logic [1:0] o, input logic go,
    input logic bs, input logic w, input logic l, input logic h,
    input logic [2:0] sc, input logic [2:0] hi);
    return {en, o, go, bs, w, l, h, sc, hi};
  endfunction

  function automatic logic [13:0] act();
    return {ena, out, tgo, busy, win, lose, hs, score, high};
  endfunction

  task automatic av(input logic st, input logic [1:0] r,
                    input logic [1:0] i, input logic v, input logic t,
                    input logic [13:0] e);
    vec_t x;
    x.st = st; x.r = r; x.i = i; x.v = v; x.t = t; x.exp = e;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] r,
                       input logic [1:0] i, input logic v, input logic t);
    start = st; rnd = r; inp = i; vld = v; tp = t;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 1);
  endtask

  // Reference model of the game, kept as a colour queue plus phase
  localparam int PH_IDLE = 0;
  localparam int PH_ADD  = 1;
  localparam int PH_SHOW = 2;
  localparam int PH_GAP  = 3;
  localparam int PH_IN   = 4;
  localparam int PH_OVER = 5;

  logic [1:0] seq[$];
  int m_ph, pos, tk, m_score, m_high;
  logic m_win, m_lose, m_hs, m_go, m_ena;
  logic [1:0] m_out;

  task automatic m_reset();
    seq.delete();
    m_ph = PH_IDLE; pos = 0; tk = 0; m_score = 0; m_high = 0;
    m_win = 0; m_lose = 0; m_hs = 0; m_go = 0; m_ena = 0; m_out = 2'b11;
  endtask

  task automatic m_end(input bit w);
    if (w) m_win = 1; else m_lose = 1;
    if (m_score > m_high) begin
      m_high = m_score;
      m_hs = 1;
    end
    m_ph = PH_OVER;
  endtask

  task automatic m_step(input logic st, input logic [1:0] r,
                        input logic [1:0] i, input logic v, input logic t);
    m_go = 0;
    m_hs = 0;
    case (m_ph)
      PH_IDLE, PH_OVER: if (st) begin
        m_win = 0; m_lose = 0; m_score = 0;
        seq.delete();
        m_ph = PH_ADD;
      end
      PH_ADD: if (seq.size() == DP) m_end(1);
        else begin
          seq.push_back(r);
          pos = 0; m_out = seq[0]; m_ena = 1; m_go = 1;
          m_ph = PH_SHOW;
        end
      PH_SHOW: if (t) begin
        m_ena = 0; m_go = 1; m_ph = PH_GAP;
      end
      PH_GAP: if (t) begin
        m_go = 1;
        if (pos == seq.size() - 1) begin
          pos = 0; tk = 0; m_ph = PH_IN;
        end else begin
          pos++; m_out = seq[pos]; m_ena = 1; m_ph = PH_SHOW;
        end
      end
      PH_IN: if (v) begin
        if (i == seq[pos]) begin
          tk = 0; m_go = 1; pos++;
          if (pos == seq.size()) begin
            m_score++; m_ph = PH_ADD;
          end
        end else m_end(0);
      end else if (t) begin
        tk++;
        if (tk == TO) m_end(0);
      end
      default: m_ph = PH_IDLE;
    endcase
  endtask

  function automatic logic [13:0] m_exp();
    logic bs;
    bs = (m_ph >= PH_ADD) && (m_ph <= PH_IN);
    return pk(m_ena, m_out, m_go, bs, m_win, m_lose, m_hs,
              LW'(m_score), LW'(m_high));
  endfunction

  logic [1:0] cols [4];

  initial begin
    rst_n = 0; start = 0; rnd = 0; inp = 0; vld = 0; tp = 0;
    cols[0] = 2'd1; cols[1] = 2'd3; cols[2] = 2'd0; cols[3] = 2'd2;

    // two games: lose in round 3 at score 2, then lose at score 1
    av(1,2,0,0,0, pk(0,3,0,1,0,0,0,0,0));
    av(0,2,0,0,0, pk(1,2,1,1,0,0,0,0,0));
    av(0,0,1,1,0, pk(1,2,0,1,0,0,0,0,0));
    av(0,0,0,0,1, pk(0,2,1,1,0,0,0,0,0));
    av(0,0,0,0,1, pk(0,2,1,1,0,0,0,0,0));
    av(0,0,2,1,0, pk(0,2,1,1,0,0,0,1,0));
    av(0,1,0,0,0, pk(1,2,1,1,0,0,0,1,0));
    av(0,0,0,0,1, pk(0,2,1,1,0,0,0,1,0));
    av(0,0,0,0,1, pk(1,1,1,1,0,0,0,1,0));
    av(0,0,0,0,1, pk(0,1,1,1,0,0,0,1,0));
    av(0,0,0,0,1, pk(0,1,1,1,0,0,0,1,0));
    av(0,0,2,1,0, pk(0,1,1,1,0,0,0,1,0));
    av(0,0,1,1,0, pk(0,1,1,1,0,0,0,2,0));
    av(0,3,0,0,0, pk(1,2,1,1,0,0,0,2,0));
    av(0,0,0,0,1, pk(0,2,1,1,0,0,0,2,0));
    av(0,0,0,0,1, pk(1,1,1,1,0,0,0,2,0));
    av(0,0,0,0,1, pk(0,1,1,1,0,0,0,2,0));
    av(0,0,0,0,1, pk(1,3,1,1,0,0,0,2,0));
    av(0,0,0,0,1, pk(0,3,1,1,0,0,0,2,0));
    av(0,0,0,0,1, pk(0,3,1,1,0,0,0,2,0));
    av(0,0,2,1,0, pk(0,3,1,1,0,0,0,2,0));
    av(0,0,0,1,0, pk(0,3,0,0,0,1,1,2,2));
    av(0,0,0,0,0, pk(0,3,0,0,0,1,0,2,2));
    av(1,0,0,0,1, pk(0,3,0,1,0,0,0,0,2));
    av(1,0,0,0,0, pk(1,0,1,1,0,0,0,0,2));
    av(1,0,0,0,1, pk(0,0,1,1,0,0,0,0,2));
    av(0,0,0,0,1, pk(0,0,1,1,0,0,0,0,2));
    av(0,0,0,1,0, pk(0,0,1,1,0,0,0,1,2));
    av(0,2,0,0,0, pk(1,0,1,1,0,0,0,1,2));
    av(0,0,0,0,1, pk(0,0,1,1,0,0,0,1,2));
    av(0,0,0,0,1, pk(1,2,1,1,0,0,0,1,2));
    av(0,0,0,0,1, pk(0,2,1,1,0,0,0,1,2));
    av(0,0,0,0,1, pk(0,2,1,1,0,0,0,1,2));
    av(0,0,1,1,0, pk(0,2,0,0,0,1,0,1,2));

    #12;
    chk("reset", 16'(act()), 16'(pk(0,3,0,0,0,0,0,0,0)));
    rst_n = 1;
    #2;
    foreach (tbl[k])
      begin
        drive(tbl[k].st, tbl[k].r, tbl[k].i, tbl[k].v, tbl[k].t);
        chk($sformatf("vec%0d", k), 16'(act()), 16'(tbl[k].exp));
      end

    // timeout: eighth tick in INPUT loses
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    ticks(2);
    ticks(7);
    chk("tmo7_lose", 16'(lose), 16'd0);
    ticks(1);
    chk("tmo8_lose", 16'(lose), 16'd1);
    chk("tmo8_hs", 16'(hs), 16'd0);
    chk("tmo8_score", 16'(score), 16'd0);

    // correct press coincident with eighth tick wins priority and clears tmo
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    ticks(2);
    ticks(7);
    drive(0, 0, 1, 1, 1);
    chk("prio_lose", 16'(lose), 16'd0);
    chk("prio_score", 16'(score), 16'd1);
    drive(0, 2, 0, 0, 0);
    ticks(4);
    ticks(7);
    drive(0, 0, 1, 1, 1);
    ticks(7);
    chk("tmo_clr_lose", 16'(lose), 16'd0);
    chk("tmo_clr_busy", 16'(busy), 16'd1);
    ticks(1);
    chk("tmo_clr_end", 16'({lose, hs, score, high}), 16'({1'b1, 1'b0, 3'd1, 3'd2}));

    // full game to DEPTH rounds
    drive(1, 0, 0, 0, 0);
    for (int r = 1; r <= DP; r++) begin
      drive(0, cols[r-1], 0, 0, 0);
      chk($sformatf("win_show%0d", r), 16'({ena, out}), 16'({1'b1, cols[0]}));
      ticks(2 * r);
      for (int k = 0; k < r; k++) drive(0, 0, cols[k], 1, 0);
      chk($sformatf("win_score%0d", r), 16'(score), 16'(r));
    end
    drive(0, 0, 0, 0, 0);
    chk("win_entry", 16'(act()), 16'(pk(0,cols[DP-1],0,0,1,0,1,4,4)));
    drive(0, 0, 0, 0, 0);
    chk("win_hold", 16'({win, hs, busy}), 16'({1'b1, 1'b0, 1'b0}));
    drive(1, 0, 0, 0, 0);
    chk("win_restart", 16'({win, busy, score, high}), 16'({1'b0, 1'b1, 3'd0, 3'd4}));

    // START ignored in SHOW, then asynchronous reset mid-SHOW
    drive(0, 2, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("show_start_ign", 16'({ena, out, busy}), 16'({1'b1, 2'd2, 1'b1}));
    #2 rst_n = 0;
    #1;
    chk("async_rst", 16'(act()), 16'(pk(0,3,0,0,0,0,0,0,0)));
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_start", 16'({busy, ena}), 16'({1'b1, 1'b0}));

    // randomized play against the model
    rst_n = 0; start = 0; vld = 0; tp = 0;
    #5 rst_n = 1;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      logic s, v, t;
      logic [1:0] r, i;
      s = ($urandom_range(0, 5) == 0);
      r = 2'($urandom_range(0, 3));
      i = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 7) < 2);
      t = ($urandom_range(0, 3) == 0);
      if (m_ph == PH_IN && v && $urandom_range(0, 15) != 0) i = seq[pos];
      m_step(s, r, i, v, t);
      drive(s, r, i, v, t);
      chk($sformatf("rand%0d", n), 16'(act()), 16'(m_exp()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
